// File: rtl/fast_field_decoder.sv
`default_nettype none
// ============================================================================
// Module   : fast_field_decoder
// Purpose  : Applies FAST field operators over one template and emits fields.
//            Optional macro FAST_DECODE_ERR_EN adds the err pulse output.
// Revision : 1.0 - initial release
// ============================================================================
module fast_field_decoder #(
  parameter int BEAT_WIDTH          = 64,
  parameter int TEMPLATE_FIELD_SIZE = 16,
  parameter int MAX_MESSAGE_SIZE    = 10
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          start,
  input  logic [TEMPLATE_FIELD_SIZE*MAX_MESSAGE_SIZE-1:0] tmpl,
  input  logic [BEAT_WIDTH*MAX_MESSAGE_SIZE-1:0]        prev,
  input  logic [MAX_MESSAGE_SIZE-1:0]                   pmap,
  input  logic [BEAT_WIDTH-1:0]                         field_data,
  input  logic                                          field_valid,
  output logic                                          field_ready,
  output logic [BEAT_WIDTH-1:0]                         out_data,
  output logic [$clog2(MAX_MESSAGE_SIZE)-1:0]           out_idx,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [BEAT_WIDTH-1:0]                         wb_data,
  output logic [$clog2(MAX_MESSAGE_SIZE)-1:0]           wb_idx,
  output logic                                          wb_en,
  output logic                                          busy,
  output logic                                          done
`ifdef FAST_DECODE_ERR_EN
  ,
  output logic                                          err
`endif
);

  localparam int IW = $clog2(MAX_MESSAGE_SIZE);
  localparam int CW = $clog2(MAX_MESSAGE_SIZE + 1);

  localparam logic [2:0]    c_OP_NONE  = 3'd0;
  localparam logic [2:0]    c_OP_CONST = 3'd1;
  localparam logic [2:0]    c_OP_COPY  = 3'd2;
  localparam logic [2:0]    c_OP_INCR  = 3'd3;
  localparam logic [2:0]    c_OP_DELTA = 3'd4;
  localparam logic [CW-1:0] c_LAST     = CW'(MAX_MESSAGE_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TEMPLATE_FIELD_SIZE-1:0] r_tmpl [MAX_MESSAGE_SIZE];
  logic [BEAT_WIDTH-1:0]          r_dict [MAX_MESSAGE_SIZE];
  logic [MAX_MESSAGE_SIZE-1:0]    r_pmap;
  logic [CW-1:0]                  r_idx;
  logic [BEAT_WIDTH-1:0]          r_out_data;
  logic [IW-1:0]                  r_out_idx;
  logic                           r_out_valid;
  logic                           r_wb_en;
  logic                           r_done;

  logic [IW-1:0]                  w_fidx;
  logic                           w_in_range;
  logic [TEMPLATE_FIELD_SIZE-1:0] w_entry;
  logic [BEAT_WIDTH-1:0]          w_prev_i;
  logic                           w_pbit;
  logic [2:0]                     w_op;
  logic                           w_end;
  logic                           w_need;
  logic                           w_wb;
  logic                           w_rsvd;
  logic [BEAT_WIDTH-1:0]          w_val;
  logic                           w_slot_free;
  logic                           w_fire;
  logic                           w_done_set;
  logic                           w_start_busy;
  logic                           w_unused_hi;

  assign w_fidx      = r_idx[IW-1:0];
  assign w_in_range  = (r_idx != c_LAST);
  assign w_entry     = w_in_range ? r_tmpl[w_fidx] : '0;
  assign w_prev_i    = w_in_range ? r_dict[w_fidx] : '0;
  assign w_pbit      = w_in_range ? r_pmap[w_fidx] : 1'b0;
  assign w_op        = w_entry[2:0];
  assign w_end       = !w_in_range || !w_entry[3];
  assign w_unused_hi = ^w_entry[TEMPLATE_FIELD_SIZE-1:4];
  assign w_slot_free = !r_out_valid || out_ready;

  // Per-op value selection; reserved codes fall through to NONE behaviour.
  always_comb begin
    w_need = 1'b1;
    w_val  = field_data;
    w_wb   = 1'b0;
    w_rsvd = 1'b0;
    case (w_op)
      c_OP_NONE: begin
        w_need = 1'b1;
      end
      c_OP_CONST: begin
        w_need = 1'b0;
        w_val  = w_prev_i;
      end
      c_OP_COPY: begin
        w_need = w_pbit;
        w_val  = w_pbit ? field_data : w_prev_i;
        w_wb   = w_pbit;
      end
      c_OP_INCR: begin
        w_need = w_pbit;
        w_val  = w_pbit ? field_data : (w_prev_i + BEAT_WIDTH'(1));
        w_wb   = 1'b1;
      end
      c_OP_DELTA: begin
        w_val  = w_prev_i + field_data;
        w_wb   = 1'b1;
      end
      default: begin
        w_rsvd = 1'b1;
      end
    endcase
  end

  assign w_fire = (r_state == S_RUN) && !w_end && w_slot_free && (!w_need || field_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Done fires straight from RUN when nothing is pending, so an empty
  // template completes two cycles after start.
  always_comb begin
    w_state_nxt  = r_state;
    w_done_set   = 1'b0;
    w_start_busy = 1'b0;
    field_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_start_busy = start;
        field_ready  = !w_end && w_need && w_slot_free;
        if (w_end) begin
          if (w_slot_free) begin
            w_done_set  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FIN;
          end
        end
      end
      S_FIN: begin
        w_start_busy = start;
        if (w_slot_free) begin
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < MAX_MESSAGE_SIZE; k++) begin
        r_tmpl[k] <= '0;
        r_dict[k] <= '0;
      end
      r_pmap      <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_wb_en     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      r_done  <= w_done_set;
      if ((r_state == S_IDLE) && start) begin
        for (int k = 0; k < MAX_MESSAGE_SIZE; k++) begin
          r_tmpl[k] <= tmpl[k*TEMPLATE_FIELD_SIZE +: TEMPLATE_FIELD_SIZE];
          r_dict[k] <= prev[k*BEAT_WIDTH +: BEAT_WIDTH];
        end
        r_pmap <= pmap;
        r_idx  <= '0;
      end
      if (w_fire) begin
        r_out_data  <= w_val;
        r_out_idx   <= w_fidx;
        r_out_valid <= 1'b1;
        r_wb_en     <= w_wb;
        r_idx       <= r_idx + CW'(1);
        if (w_wb) begin
          r_dict[w_fidx] <= w_val;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef FAST_DECODE_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_fire && w_rsvd) || w_start_busy;
    end
  end

  assign err = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = w_rsvd | w_start_busy;
`endif

  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign wb_data   = r_out_data;
  assign wb_idx    = r_out_idx;
  assign wb_en     = r_wb_en;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule
`default_nettype wire
